// File: rtl/inexrecur_tuple_writer.sv
// Producer side of the inexact-recursion tuple store: filters dead-branch
// (i,z,k,l) tuples and streams survivors into the tuple regfile write port.
module inexrecur_tuple_writer #(
  parameter int ADDR_W  = 12,
  parameter int FIELD_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic        [FIELD_W-1:0] in_i,
  input  logic signed [FIELD_W-1:0] in_z,
  input  logic        [FIELD_W-1:0] in_k,
  input  logic        [FIELD_W-1:0] in_l,
  input  logic                      in_last,
  output logic                      we,
  output logic      [4*FIELD_W-1:0] w_data,
  output logic         [ADDR_W-1:0] wr_addr,
  output logic           [ADDR_W:0] wr_count,
  output logic           [ADDR_W:0] drop_count,
  output logic                      full,
  output logic                      done,
  output logic                      overflow
);

  localparam int WORD_W = 4 * FIELD_W;
  localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_CNT = DEPTH - (ADDR_W+1)'(1);
  localparam logic signed [FIELD_W-1:0] Z_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FULL,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic                accept;
  logic                keep_p0;
  logic   [WORD_W-1:0] word_p0;

  logic                vld_p1;
  logic   [WORD_W-1:0] data_p1;
  logic   [ADDR_W-1:0] addr_p1;
  logic     [ADDR_W:0] wr_count_q;
  logic     [ADDR_W:0] drop_count_q;
  logic                full_q;
  logic                done_q;
  logic                overflow_q;

  function automatic logic [WORD_W-1:0] pack_tuple(
    input logic        [FIELD_W-1:0] i,
    input logic signed [FIELD_W-1:0] z,
    input logic        [FIELD_W-1:0] k,
    input logic        [FIELD_W-1:0] l
  );
    return {i, z, k, l};
  endfunction

  // A branch is alive while its mismatch budget is non-negative and its
  // SA interval is non-empty (k == l is a single-row interval).
  function automatic logic keep_tuple(
    input logic signed [FIELD_W-1:0] z,
    input logic        [FIELD_W-1:0] k,
    input logic        [FIELD_W-1:0] l
  );
    return (z >= Z_ZERO) && (k <= l);
  endfunction

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (&v) ? v : v + (ADDR_W+1)'(1);
  endfunction

  // Stage p0: handshake and filter decision on the incoming tuple
  assign accept  = in_valid && in_ready;
  assign keep_p0 = keep_tuple(in_z, in_k, in_l);
  assign word_p0 = pack_tuple(in_i, in_z, in_k, in_l);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (start) begin
          state_nxt = S_RUN;
        end else if (accept && in_last) begin
          state_nxt = S_DONE;
        end else if (accept && keep_p0 && (wr_count_q == LAST_CNT)) begin
          state_nxt = S_FULL;
        end
      end
      S_FULL, S_DONE: begin
        if (start) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_RUN) && !start;
  end

  // Stage p1: registered write port and status, one cycle after accept
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      data_p1      <= '0;
      addr_p1      <= '0;
      wr_count_q   <= '0;
      drop_count_q <= '0;
      full_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      vld_p1 <= accept && keep_p0;
      if (start) begin
        addr_p1      <= '0;
        wr_count_q   <= '0;
        drop_count_q <= '0;
        full_q       <= 1'b0;
        done_q       <= 1'b0;
        overflow_q   <= 1'b0;
      end else begin
        if (accept && keep_p0) begin
          data_p1    <= word_p0;
          addr_p1    <= wr_count_q[ADDR_W-1:0];
          wr_count_q <= wr_count_q + (ADDR_W+1)'(1);
          if (wr_count_q == LAST_CNT) full_q <= 1'b1;
        end
        if (accept && !keep_p0) drop_count_q <= sat_inc(drop_count_q);
        if (accept && in_last) done_q <= 1'b1;
        if ((state == S_FULL) && in_valid) overflow_q <= 1'b1;
      end
    end
  end

  assign we         = vld_p1;
  assign w_data     = data_p1;
  assign wr_addr    = addr_p1;
  assign wr_count   = wr_count_q;
  assign drop_count = drop_count_q;
  assign full       = full_q;
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_inexrecur_tuple_writer.sv
// Bench for inexrecur_tuple_writer: scenario tasks against a behavioural
// model of the store (counts, flags and the last written word).
module tb_inexrecur_tuple_writer;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last;
  logic  [7:0] in_i, in_z, in_k, in_l;
  logic        in_ready, we, full, done, overflow;
  logic [31:0] w_data;
  logic [11:0] wr_addr;
  logic [12:0] wr_count, drop_count;

  inexrecur_tuple_writer #(.ADDR_W(12), .FIELD_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_z(in_z), .in_k(in_k), .in_l(in_l), .in_last(in_last),
    .we(we), .w_data(w_data), .wr_addr(wr_addr), .wr_count(wr_count),
    .drop_count(drop_count), .full(full), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model of what the store should look like after each cycle
  bit          m_run, m_full_state, m_done, m_ovf, m_we;
  int          m_count, m_drops;
  logic [31:0] m_data;
  logic [11:0] m_addr;
  bit          obs_ready, exp_ready;

  task automatic model_reset();
    m_run = 0; m_full_state = 0; m_done = 0; m_ovf = 0; m_we = 0;
    m_count = 0; m_drops = 0; m_data = '0; m_addr = '0;
  endtask

  // Drive one cycle from a negedge; returns at the following negedge.
  task automatic drive(input bit v, input logic [7:0] ti, tz, tk, tl,
                       input bit last, input bit st);
    bit acc, keep;
    in_valid = v; in_i = ti; in_z = tz; in_k = tk; in_l = tl;
    in_last = last; start = st;
    #1;
    obs_ready = in_ready;
    exp_ready = m_run && !st;
    acc  = v && exp_ready;
    keep = (tz < 8'd128) && (tk <= tl);
    m_we = 0;
    if (st) begin
      m_count = 0; m_drops = 0; m_done = 0; m_ovf = 0; m_addr = '0;
      m_run = 1; m_full_state = 0;
    end else begin
      if (m_full_state && v) m_ovf = 1;
      if (acc) begin
        if (keep) begin
          m_we = 1; m_data = {ti, tz, tk, tl}; m_addr = m_count[11:0];
          m_count++;
        end else if (m_drops < 8191) begin
          m_drops++;
        end
        if (last) begin
          m_done = 1; m_run = 0;
        end else if (m_count == 4096) begin
          m_run = 0; m_full_state = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; start = 0; in_last = 0;
  endtask

  task automatic rand_kept(output logic [7:0] ti, tz, tk, tl);
    ti = 8'($urandom);
    tz = 8'($urandom_range(0, 127));
    tk = 8'($urandom);
    tl = 8'($urandom_range(int'(tk), 255));
  endtask

  task automatic test_reset();
    rst = 1; start = 0; in_valid = 0; in_last = 0;
    in_i = 0; in_z = 0; in_k = 0; in_l = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    n_chk++; if ({we, w_data, wr_addr, wr_count, drop_count, full, done, overflow} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got we=%b data=%h addr=%0d cnt=%0d drop=%0d full=%b done=%b ovf=%b, want all 0",
                        we, w_data, wr_addr, wr_count, drop_count, full, done, overflow);
    end
    n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    rst = 0;
    drive(1, 8'h11, 8'h00, 8'h01, 8'h02, 0, 0);
    n_chk++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b want 0", obs_ready); end
    n_chk++; if (we !== 1'b0) begin n_err++; $display("FAIL idle_we: got %b want 0", we); end
  endtask

  task automatic test_basic();
    logic [31:0] words [3] = '{32'h01020309, 32'h02000505, 32'h03010007};
    drive(0, 0, 0, 0, 0, 0, 1);
    n_chk++; if (wr_count !== 13'd0) begin n_err++; $display("FAIL basic_start_cnt: got %0d want 0", wr_count); end
    for (int n = 0; n < 3; n++) begin
      drive(1, words[n][31:24], words[n][23:16], words[n][15:8], words[n][7:0], 0, 0);
      n_chk++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready[%0d]: got %b want 1", n, obs_ready); end
      n_chk++; if (we !== 1'b1) begin n_err++; $display("FAIL basic_we[%0d]: got %b want 1", n, we); end
      n_chk++; if (w_data !== words[n]) begin n_err++; $display("FAIL basic_data[%0d]: got %h want %h", n, w_data, words[n]); end
      n_chk++; if (wr_addr !== 12'(n)) begin n_err++; $display("FAIL basic_addr[%0d]: got %0d want %0d", n, wr_addr, n); end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (we !== 1'b0) begin n_err++; $display("FAIL basic_we_idle: got %b want 0", we); end
    n_chk++; if (wr_count !== 13'd3) begin n_err++; $display("FAIL basic_cnt: got %0d want 3", wr_count); end
    n_chk++; if (drop_count !== 13'd0) begin n_err++; $display("FAIL basic_drop: got %0d want 0", drop_count); end
    n_chk++; if (w_data !== 32'h03010007) begin n_err++; $display("FAIL basic_hold: got %h want 03010007", w_data); end
  endtask

  task automatic test_filter();
    drive(1, 8'h04, 8'hFF, 8'h01, 8'h02, 0, 0);
    n_chk++; if (we !== 1'b0) begin n_err++; $display("FAIL filter_neg_z_we: got %b want 0", we); end
    drive(1, 8'h05, 8'h01, 8'h09, 8'h03, 0, 0);
    n_chk++; if (we !== 1'b0) begin n_err++; $display("FAIL filter_k_gt_l_we: got %b want 0", we); end
    n_chk++; if (drop_count !== 13'd2) begin n_err++; $display("FAIL filter_drop: got %0d want 2", drop_count); end
    drive(1, 8'h06, 8'h00, 8'h03, 8'h03, 0, 0);
    n_chk++; if (we !== 1'b1 || w_data !== 32'h06000303) begin
      n_err++; $display("FAIL filter_keep_eq: got we=%b data=%h want we=1 data=06000303", we, w_data);
    end
    n_chk++; if (wr_addr !== 12'd3 || wr_count !== 13'd4) begin
      n_err++; $display("FAIL filter_addr: got addr=%0d cnt=%0d want addr=3 cnt=4", wr_addr, wr_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] ti, tz, tk, tl;
    for (int n = 0; n < 400; n++) begin
      ti = 8'($urandom); tz = 8'($urandom); tk = 8'($urandom); tl = 8'($urandom);
      if ($urandom_range(0, 3) == 0) tl = tk;
      drive($urandom_range(0, 9) < 7, ti, tz, tk, tl, 0, 0);
      n_chk++; if (obs_ready !== exp_ready) begin n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", n, obs_ready, exp_ready); end
      n_chk++; if (we !== m_we) begin n_err++; $display("FAIL rand_we[%0d]: got %b want %b", n, we, m_we); end
      n_chk++; if (w_data !== m_data || wr_addr !== m_addr) begin
        n_err++; $display("FAIL rand_word[%0d]: got %h@%0d want %h@%0d", n, w_data, wr_addr, m_data, m_addr);
      end
      n_chk++; if (wr_count !== 13'(m_count) || drop_count !== 13'(m_drops)) begin
        n_err++; $display("FAIL rand_counts[%0d]: got cnt=%0d drop=%0d want cnt=%0d drop=%0d", n, wr_count, drop_count, m_count, m_drops);
      end
    end
  endtask

  task automatic test_start_collision();
    logic [11:0] pre;
    pre = 12'(m_count);
    drive(1, 8'h21, 8'h01, 8'h02, 8'h03, 0, 0);
    drive(1, 8'h22, 8'h01, 8'h02, 8'h03, 0, 1);
    n_chk++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL collide_ready: got %b want 0", obs_ready); end
    n_chk++; if (we !== 1'b0) begin n_err++; $display("FAIL collide_we: got %b want 0", we); end
    n_chk++; if (wr_count !== 13'd0 || drop_count !== 13'd0 || wr_addr !== 12'd0) begin
      n_err++; $display("FAIL collide_clear: got cnt=%0d drop=%0d addr=%0d want 0/0/0", wr_count, drop_count, wr_addr);
    end
    n_chk++; if (w_data !== 32'h21010203) begin n_err++; $display("FAIL collide_pending_data: got %h want 21010203 (pre addr %0d)", w_data, pre); end
    drive(1, 8'h23, 8'h00, 8'h00, 8'h00, 0, 0);
    n_chk++; if (we !== 1'b1 || wr_addr !== 12'd0 || wr_count !== 13'd1) begin
      n_err++; $display("FAIL collide_restart: got we=%b addr=%0d cnt=%0d want 1/0/1", we, wr_addr, wr_count);
    end
  endtask

  task automatic test_last();
    drive(1, 8'h07, 8'h00, 8'h02, 8'h04, 1, 0);
    n_chk++; if (we !== 1'b1 || done !== 1'b1 || w_data !== 32'h07000204) begin
      n_err++; $display("FAIL last_write: got we=%b done=%b data=%h want 1/1/07000204", we, done, w_data);
    end
    drive(1, 8'h08, 8'h00, 8'h00, 8'h01, 0, 0);
    n_chk++; if (obs_ready !== 1'b0 || we !== 1'b0) begin
      n_err++; $display("FAIL last_after: got ready=%b we=%b want 0/0", obs_ready, we);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    n_chk++; if (wr_count !== 13'd0 || done !== 1'b0) begin
      n_err++; $display("FAIL last_restart: got cnt=%0d done=%b want 0/0", wr_count, done);
    end
    drive(1, 8'h09, 8'h00, 8'h09, 8'h01, 1, 0);
    n_chk++; if (we !== 1'b0 || done !== 1'b1 || drop_count !== 13'd1) begin
      n_err++; $display("FAIL last_dropped: got we=%b done=%b drop=%0d want 0/1/1", we, done, drop_count);
    end
    drive(1, 8'h0A, 8'h00, 8'h00, 8'h01, 0, 0);
    n_chk++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL last_dropped_ready: got %b want 0", obs_ready); end
  endtask

  task automatic test_fill(input bit last_on_fill);
    logic [7:0] ti, tz, tk, tl;
    int bad = 0;
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 4096; n++) begin
      rand_kept(ti, tz, tk, tl);
      drive(1, ti, tz, tk, tl, last_on_fill && (n == 4095), 0);
      if (we !== 1'b1 || wr_addr !== 12'(n) || w_data !== {ti, tz, tk, tl}) bad++;
    end
    n_chk++; if (bad != 0) begin n_err++; $display("FAIL fill_stream: %0d bad writes, want 0", bad); end
    n_chk++; if (wr_addr !== 12'd4095 || wr_count !== 13'd4096 || full !== 1'b1) begin
      n_err++; $display("FAIL fill_end: got addr=%0d cnt=%0d full=%b want 4095/4096/1", wr_addr, wr_count, full);
    end
    n_chk++; if (done !== last_on_fill) begin n_err++; $display("FAIL fill_done: got %b want %b", done, last_on_fill); end
    drive(1, 8'h55, 8'h00, 8'h00, 8'h01, 0, 0);
    n_chk++; if (obs_ready !== 1'b0 || we !== 1'b0) begin
      n_err++; $display("FAIL fill_hold: got ready=%b we=%b want 0/0", obs_ready, we);
    end
    n_chk++; if (overflow !== m_ovf) begin n_err++; $display("FAIL fill_overflow: got %b want %b", overflow, m_ovf); end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (we !== 1'b0 || wr_count !== 13'd4096 || overflow !== m_ovf) begin
      n_err++; $display("FAIL fill_sticky: got we=%b cnt=%0d ovf=%b want 0/4096/%b", we, wr_count, overflow, m_ovf);
    end
  endtask

  task automatic test_rst_mid();
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 8'h31, 8'h00, 8'h01, 8'h02, 0, 0);
    rst = 1; in_valid = 1; in_i = 8'h32; in_z = 0; in_k = 0; in_l = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    model_reset();
    n_chk++; if ({we, w_data, wr_addr, wr_count, drop_count, full, done, overflow, in_ready} !== '0) begin
      n_err++; $display("FAIL rst_mid: got we=%b data=%h addr=%0d cnt=%0d ready=%b, want all 0",
                        we, w_data, wr_addr, wr_count, in_ready);
    end
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_filter();
    test_random();
    test_start_collision();
    test_last();
    test_fill(0);
    test_fill(1);
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/inexrecur_tuple_writer.md
Name: inexrecur_tuple_writer

Overview:
- Producer side of the inexact-recursion tuple store.
- Accepts (i, z, k, l) search-state tuples from the recursion engine over a valid/ready handshake and discards tuples that are dead branches.
- Packs each surviving tuple into one 32-bit word and drives the sequential-write port (we, w_data) of the 4096-entry tuple regfile.
- Tracks write address, occupancy, drops, full and done status for the downstream sequential/random reader.

Parameters:
- ADDR_W, 12, regfile address width; depth = 2**ADDR_W words.
- FIELD_W, 8, width of each of i, z, k, l; w_data width = 4*FIELD_W.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: clear counters and flags, enter RUN.
- in_valid  input  1  tuple present.
- in_ready  output  1  block can accept a tuple this cycle.
- in_i  input  FIELD_W  query index, unsigned.
- in_z  input  FIELD_W  remaining mismatch budget, two's-complement signed.
- in_k  input  FIELD_W  SA interval lower bound, unsigned.
- in_l  input  FIELD_W  SA interval upper bound, unsigned.
- in_last  input  1  qualifies the final tuple of a recursion run.
- we  output  1  regfile write enable, one cycle per stored word.
- w_data  output  4*FIELD_W  packed word {i,z,k,l}; i in [31:24], z [23:16], k [15:8], l [7:0].
- wr_addr  output  ADDR_W  address of the word currently on w_data; valid when we=1.
- wr_count  output  ADDR_W+1  number of words written since start (0..4096).
- drop_count  output  ADDR_W+1  number of tuples discarded since start; saturates at all-ones.
- full  output  1  wr_count == 2**ADDR_W.
- done  output  1  in_last tuple processed.
- overflow  output  1  sticky; in_valid was seen while in FULL.

Behaviour:
- Reset: state=IDLE; we, w_data, wr_addr, wr_count, drop_count, full, done, overflow all 0; in_ready=0.
- FSM states: IDLE, RUN, FULL, DONE.
  - IDLE -start-> RUN.
  - RUN -accept of in_last-> DONE.
  - RUN -write that makes wr_count = 2**ADDR_W (and not in_last)-> FULL.
  - FULL -start-> RUN.
  - DONE -start-> RUN.
  - start from RUN also restarts into RUN.
- in_ready = (state==RUN) && !start. It is combinational from the state register and does not depend on in_valid.
- Accept: in_valid && in_ready.
- Filter, applied on accept:
  - Drop if in_z is negative (MSB set).
  - Drop if in_k > in_l (unsigned compare).
  - in_k == in_l is kept.
- Latency 1:
  - A kept tuple accepted in cycle N gives we=1 in cycle N+1, with w_data = packed tuple and wr_addr = wr_count value before the increment.
  - wr_count increments in cycle N+1.
  - A dropped tuple gives we=0 and increments drop_count in cycle N+1.
- Throughput: one tuple per cycle; back-to-back accepts give back-to-back writes at consecutive addresses.
- we is a single-cycle pulse per word. w_data holds its last value when we=0.
- Boundaries:
  - Accepting the 4096th kept tuple: written to address 4095, then wr_count=4096, full=1, state=FULL, and in_ready drops in the same cycle as that we.
  - No wrap-around; nothing is written in FULL.
  - in_last on the tuple that fills the store: DONE takes priority; done=1 and full=1 are both set.
  - in_last on a dropped tuple still moves the FSM to DONE.
  - done rises in cycle N+1, alongside the final we if that tuple is kept.
  - overflow sets on any cycle with state==FULL && in_valid, and clears only on start or rst.
  - start in the same cycle as in_valid: start wins, in_ready=0, and the tuple is not accepted.
  - start clears wr_count, wr_addr, drop_count, full, done and overflow in the next cycle. A write pending from an accept in the previous cycle still completes, using its pre-start address, and is not counted.
  - The regfile's internal sequential write pointer restarts only on its own reset. The top level resets it with the same event that pulses start.
  - rst mid-run aborts immediately: no we in the following cycle.

Test Plan:
- rst, start, then 3 tuples back-to-back: (1,2,3,9), (2,0,5,5), (3,1,0,7) -> we high 3 consecutive cycles; w_data 0x01020309, 0x02000505, 0x03010007; wr_addr 0,1,2; wr_count=3; drop_count=0.
- Tuples (4,0xFF,1,2) and (5,1,9,3) -> both dropped, no we, drop_count=2; a following (6,0,3,3) is written at the next address.
- Stream 4096 kept tuples, then hold in_valid=1 -> last write at address 4095; full=1; in_ready=0; overflow=1 the cycle after in_valid is seen in FULL; no further we.
- Tuple with in_last=1 = (7,0,2,4) -> we and done=1 in the same cycle; in_ready=0 afterwards; a start pulse returns to RUN with wr_count=0 and done=0.
- start asserted together with in_valid -> no accept that cycle, no we in the next cycle.
- rst asserted one cycle after an accept -> no we emitted, all outputs 0 the next cycle.
